// File: rtl/core_pkg.sv
// Shared constants and types for the 16-bit five-stage core.
// It holds the opcode values, the register-index and counter widths, and the
// state encoding of the hazard controller. The hazard comparator lives here as
// a helper function because other stages may reuse it.
package core_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LOAD = 4'b1000;

    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 16;

    // Hazard controller state encoding. The values are visible on ctrl_state.
    typedef logic [1:0] ctrl_state_t;
    localparam ctrl_state_t ST_RUN        = 2'd0;
    localparam ctrl_state_t ST_LOAD_STALL = 2'd1;
    localparam ctrl_state_t ST_FLUSH      = 2'd2;
    localparam ctrl_state_t ST_MEM_WAIT   = 2'd3;

    // True when a non-zero destination is read by either source operand.
    // r0 is hardwired to zero, so it never creates a dependency.
    function automatic logic dest_feeds_src(
        input logic [REG_IDX_W-1:0] dest,
        input logic [REG_IDX_W-1:0] src1,
        input logic [REG_IDX_W-1:0] src2
    );
        return (dest != '0) && ((dest == src1) || (dest == src2));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear.
// The count stops at all-ones instead of wrapping, so a debug reader can
// tell that an overflow happened.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_reg;

    // Count up on inc, hold at all-ones, and let clear take priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != ALL_ONES)) begin
            count_reg <= count_reg + ONE;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core.
// It owns every pipeline-register enable and squash. It inserts one bubble
// on a load-use hazard and flushes IF/ID on a mispredict resolved in execute.
// It freezes the whole pipeline while data memory is busy, and it keeps
// saturating stall and flush counters for debug.
//
// The state that governs the current cycle (act_state) is decided
// combinationally from the registered state, the inputs and the execute-stage
// shadow registers. A stall or flush therefore takes effect in the same cycle
// that its condition is seen. ctrl_state reports this in-effect state.
// state_reg records it for the next cycle.
module pipeline_hazard_ctrl #(
    parameter logic [3:0] OP_LOAD = core_pkg::OP_LOAD,
    parameter logic [3:0] OP_NOP  = core_pkg::OP_NOP,
    parameter int         CNT_W   = core_pkg::CNT_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [3:0]                     opcode_id,
    input  logic [core_pkg::REG_IDX_W-1:0] reg1_index_id,
    input  logic [core_pkg::REG_IDX_W-1:0] reg2_index_id,
    input  logic [core_pkg::REG_IDX_W-1:0] dest_index_id,
    input  logic                           mispredict_ex,
    input  logic                           mem_busy_mem,
    output logic                           pc_write_en,
    output logic                           if_id_write_en,
    output logic                           id_ex_write_en,
    output logic                           ex_mem_write_en,
    output logic                           id_ex_bubble,
    output logic                           flush_if_id,
    output logic [1:0]                     ctrl_state,
    output logic [CNT_W-1:0]               stall_count,
    output logic [CNT_W-1:0]               flush_count
);

    localparam int RW = core_pkg::REG_IDX_W;

    // Execute-stage shadow of the instruction now in ID/EX.
    logic          ex_is_load_reg;
    logic          ex_is_load_next;
    logic [RW-1:0] ex_dest_reg;
    logic [RW-1:0] ex_dest_next;

    // A mispredict seen while memory is busy is remembered until the freeze ends.
    logic pending_flush_reg;
    logic pending_flush_next;

    core_pkg::ctrl_state_t state_reg;
    core_pkg::ctrl_state_t act_state;

    logic          load_use_hazard;
    logic [3:0]    id_ex_opcode;

    // Counter array: index 0 counts stall cycles, index 1 counts flush events.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign load_use_hazard = ex_is_load_reg &&
        core_pkg::dest_feeds_src(ex_dest_reg, reg1_index_id, reg2_index_id);

    // Decide which state governs this cycle: busy, then any flush, then load-use.
    // Reset forces RUN so the outputs take their idle values without a clock.
    always_comb begin
        act_state = core_pkg::ST_RUN;
        if (!rst_n) begin
            act_state = core_pkg::ST_RUN;
        end else if (mem_busy_mem) begin
            act_state = core_pkg::ST_MEM_WAIT;
        end else if ((state_reg == core_pkg::ST_MEM_WAIT) && pending_flush_reg) begin
            act_state = core_pkg::ST_FLUSH;
        end else if (mispredict_ex) begin
            act_state = core_pkg::ST_FLUSH;
        end else if (load_use_hazard) begin
            act_state = core_pkg::ST_LOAD_STALL;
        end
    end

    // Drive the enables and squashes for the state in effect this cycle.
    always_comb begin
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        id_ex_write_en  = 1'b1;
        ex_mem_write_en = 1'b1;
        id_ex_bubble    = 1'b0;
        flush_if_id     = 1'b0;
        case (act_state)
            core_pkg::ST_LOAD_STALL: begin
                // Hold the dependent instruction in decode and send a bubble on.
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_bubble   = 1'b1;
            end
            core_pkg::ST_FLUSH: begin
                // The PC loads the corrected target while both wrong-path slots are squashed.
                id_ex_bubble = 1'b1;
                flush_if_id  = 1'b1;
            end
            core_pkg::ST_MEM_WAIT: begin
                pc_write_en     = 1'b0;
                if_id_write_en  = 1'b0;
                id_ex_write_en  = 1'b0;
                ex_mem_write_en = 1'b0;
            end
            default: begin
            end
        endcase
    end

    assign ctrl_state = act_state;

    // Work out what ID/EX will hold next: a bubble becomes a NOP, and a frozen stage keeps its value.
    always_comb begin
        id_ex_opcode    = id_ex_bubble ? OP_NOP : opcode_id;
        ex_is_load_next = ex_is_load_reg;
        ex_dest_next    = ex_dest_reg;
        if (id_ex_write_en) begin
            ex_is_load_next = (id_ex_opcode == OP_LOAD);
            ex_dest_next    = id_ex_bubble ? '0 : dest_index_id;
        end
    end

    // Set the pending flush on a mispredict during the freeze, and drop it once the freeze ends.
    always_comb begin
        pending_flush_next = 1'b0;
        if (act_state == core_pkg::ST_MEM_WAIT) begin
            pending_flush_next = pending_flush_reg | mispredict_ex;
        end
    end

    // Register the state, the shadow registers and the pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= core_pkg::ST_RUN;
            ex_is_load_reg    <= 1'b0;
            ex_dest_reg       <= '0;
            pending_flush_reg <= 1'b0;
        end else begin
            state_reg         <= act_state;
            ex_is_load_reg    <= ex_is_load_next;
            ex_dest_reg       <= ex_dest_next;
            pending_flush_reg <= pending_flush_next;
        end
    end

    assign cnt_inc[0] = (act_state == core_pkg::ST_LOAD_STALL) ||
                        (act_state == core_pkg::ST_MEM_WAIT);
    assign cnt_inc[1] = (act_state == core_pkg::ST_FLUSH);

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        sat_counter #(
            .WIDTH (CNT_W)
        ) u_sat_counter (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (1'b0),
            .inc   (cnt_inc[gi]),
            .count (cnt_val[gi])
        );
    end

    assign stall_count = cnt_val[0];
    assign flush_count = cnt_val[1];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
// A reference model tracks which instruction sits in execute, whether a freeze
// is in progress with a remembered mispredict, and the two counters. It derives
// the expected controls from the hazard-priority rules. Directed steps come
// first, then randomized steps, then an asynchronous reset during a freeze.
module tb_pipeline_hazard_ctrl;

    localparam logic [3:0] LOAD = 4'b1000;
    localparam logic [3:0] NOP  = 4'b0000;
    localparam logic [3:0] ADD  = 4'b0001;

    localparam int M_RUN   = 0;
    localparam int M_STALL = 1;
    localparam int M_FLUSH = 2;
    localparam int M_WAIT  = 3;
    localparam int CNT_MAX = 65535;

    logic        clk;
    logic        rst_n;
    logic [3:0]  opcode_id;
    logic [4:0]  reg1_index_id;
    logic [4:0]  reg2_index_id;
    logic [4:0]  dest_index_id;
    logic        mispredict_ex;
    logic        mem_busy_mem;
    logic        pc_write_en;
    logic        if_id_write_en;
    logic        id_ex_write_en;
    logic        ex_mem_write_en;
    logic        id_ex_bubble;
    logic        flush_if_id;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int n_pass;
    int n_total;
    int n_fail;
    int step_no;

    // Reference model state
    bit m_ex_load;
    int m_ex_dest;
    bit m_freeze_pending;
    int m_stall;
    int m_flush;

    pipeline_hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode_id       (opcode_id),
        .reg1_index_id   (reg1_index_id),
        .reg2_index_id   (reg2_index_id),
        .dest_index_id   (dest_index_id),
        .mispredict_ex   (mispredict_ex),
        .mem_busy_mem    (mem_busy_mem),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en),
        .id_ex_write_en  (id_ex_write_en),
        .ex_mem_write_en (ex_mem_write_en),
        .id_ex_bubble    (id_ex_bubble),
        .flush_if_id     (flush_if_id),
        .ctrl_state      (ctrl_state),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ex_load        = 1'b0;
        m_ex_dest        = 0;
        m_freeze_pending = 1'b0;
        m_stall          = 0;
        m_flush          = 0;
    endtask

    // Apply one decode-stage instruction and check that cycle's controls against the model.
    // Call it just after a rising edge; it returns just after the next rising edge.
    task automatic step(input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] d, input bit mis, input bit busy);
        int  mode;
        bit  frozen;
        bit  squash;
        opcode_id     = op;
        reg1_index_id = r1;
        reg2_index_id = r2;
        dest_index_id = d;
        mispredict_ex = mis;
        mem_busy_mem  = busy;
        @(negedge clk);
        if (busy)
            mode = M_WAIT;
        else if (m_freeze_pending || mis)
            mode = M_FLUSH;
        else if (m_ex_load && m_ex_dest != 0 && (m_ex_dest == int'(r1) || m_ex_dest == int'(r2)))
            mode = M_STALL;
        else
            mode = M_RUN;
        frozen = (mode == M_WAIT);
        squash = (mode == M_STALL) || (mode == M_FLUSH);
        // The PC and IF/ID advance unless memory is frozen or a load-use stall holds them.
        check($sformatf("s%0d_pc_we", step_no), 32'(pc_write_en),
              32'(!frozen && mode != M_STALL));
        check($sformatf("s%0d_ifid_we", step_no), 32'(if_id_write_en),
              32'(!frozen && mode != M_STALL));
        check($sformatf("s%0d_idex_we", step_no), 32'(id_ex_write_en), 32'(!frozen));
        check($sformatf("s%0d_exmem_we", step_no), 32'(ex_mem_write_en), 32'(!frozen));
        check($sformatf("s%0d_bubble", step_no), 32'(id_ex_bubble), 32'(squash));
        check($sformatf("s%0d_flush", step_no), 32'(flush_if_id), 32'(mode == M_FLUSH));
        check($sformatf("s%0d_state", step_no), 32'(ctrl_state), 32'(mode));
        check($sformatf("s%0d_stall_cnt", step_no), 32'(stall_count), 32'(m_stall));
        check($sformatf("s%0d_flush_cnt", step_no), 32'(flush_count), 32'(m_flush));
        $display("step %0d op=%h r1=%0d r2=%0d d=%0d mis=%0b busy=%0b mode=%0d stall=%0d flush=%0d",
                 step_no, op, r1, r2, d, mis, busy, mode, stall_count, flush_count);
        @(posedge clk);
        #1;
        // Advance the model: a frozen pipeline remembers mispredicts; otherwise execute takes the decode slot.
        if (frozen) begin
            m_freeze_pending = m_freeze_pending | mis;
        end else begin
            m_freeze_pending = 1'b0;
            if (squash) begin
                m_ex_load = 1'b0;
                m_ex_dest = 0;
            end else begin
                m_ex_load = (op == LOAD);
                m_ex_dest = int'(d);
            end
        end
        if ((mode == M_STALL || mode == M_WAIT) && m_stall < CNT_MAX) m_stall++;
        if (mode == M_FLUSH && m_flush < CNT_MAX) m_flush++;
        step_no++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        n_fail  = 0;
        step_no = 0;
        model_reset();
        rst_n         = 1'b0;
        opcode_id     = NOP;
        reg1_index_id = '0;
        reg2_index_id = '0;
        dest_index_id = '0;
        mispredict_ex = 1'b0;
        mem_busy_mem  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc_we", 32'(pc_write_en), 32'd1);
        check("rst_ifid_we", 32'(if_id_write_en), 32'd1);
        check("rst_bubble", 32'(id_ex_bubble), 32'd0);
        check("rst_flush", 32'(flush_if_id), 32'd0);
        check("rst_state", 32'(ctrl_state), 32'd0);
        check("rst_stall_cnt", 32'(stall_count), 32'd0);
        check("rst_flush_cnt", 32'(flush_count), 32'd0);
        rst_n = 1'b1;

        // Load r3, then an add reading r3: one stall cycle, then RUN
        step(LOAD, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
        step(ADD, 5'd3, 5'd1, 5'd4, 1'b0, 1'b0);
        step(ADD, 5'd3, 5'd1, 5'd4, 1'b0, 1'b0);
        check("lu_stall_cnt", 32'(stall_count), 32'd1);

        // Load r0 followed by a reader of r0; load r5 followed by a reader of r6
        step(LOAD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step(ADD, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0);
        step(LOAD, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
        step(ADD, 5'd6, 5'd6, 5'd2, 1'b0, 1'b0);
        check("no_stall_cnt", 32'(stall_count), 32'd1);

        // Mispredict pulse in RUN
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("mp_flush_cnt", 32'(flush_count), 32'd1);

        // Memory busy for three cycles, mispredict on the second, then one flush
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("mw_stall_cnt", 32'(stall_count), 32'd4);
        check("mw_flush_cnt", 32'(flush_count), 32'd2);

        // A hazard and a mispredict in the same cycle: flush only
        step(LOAD, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0);
        step(ADD, 5'd7, 5'd1, 5'd2, 1'b1, 1'b0);
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("hz_mp_stall_cnt", 32'(stall_count), 32'd4);
        check("hz_mp_flush_cnt", 32'(flush_count), 32'd3);

        // Randomized traffic over a small register range so hazards occur often
        for (int i = 0; i < 300; i++) begin
            logic [3:0] rop;
            rop = ($urandom_range(0, 2) == 0) ? LOAD : 4'($urandom_range(0, 15));
            step(rop, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 6) == 0));
        end

        // Reset during a freeze with a pending flush: outputs return without a clock
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        mem_busy_mem  = 1'b1;
        mispredict_ex = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc_we", 32'(pc_write_en), 32'd1);
        check("arst_ifid_we", 32'(if_id_write_en), 32'd1);
        check("arst_idex_we", 32'(id_ex_write_en), 32'd1);
        check("arst_exmem_we", 32'(ex_mem_write_en), 32'd1);
        check("arst_bubble", 32'(id_ex_bubble), 32'd0);
        check("arst_flush", 32'(flush_if_id), 32'd0);
        check("arst_state", 32'(ctrl_state), 32'd0);
        check("arst_stall_cnt", 32'(stall_count), 32'd0);
        check("arst_flush_cnt", 32'(flush_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        // The dropped pending flush must not reappear after release
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("post_rst_state", 32'(ctrl_state), 32'd0);
        check("post_rst_flush_cnt", 32'(flush_count), 32'd0);
        check("post_rst_stall_cnt", 32'(stall_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
